// File: rtl/param_fifo.sv
// param_fifo: parameterizable synchronous FIFO. DEPTH does not have to be a power of two.
//
// Read modes, selected by FWFT:
//   FWFT=0  Standard mode. An accepted pop loads the head word into a register.
//           data_out shows it one cycle after the pop edge and holds at all other times.
//   FWFT=1  First-word-fall-through. The head word is presented whenever the FIFO is
//           not empty, and read_en acknowledges it.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   write_en, data_in        push request and data
//   read_en                  pop request
//   data_out                 read data
//   empty, full              count == 0, count == DEPTH
//   almost_empty             count <= AE_THRESH
//   almost_full              count >= AF_THRESH
//   count                    current occupancy
//   overflow, underflow      sticky flags for a write while full / a read while empty
module param_fifo #(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter bit FWFT      = 1'b0,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_en,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] dout_q;
  logic             push, pop;

  // Pointers wrap explicitly, so that a DEPTH that is not a power of two works.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flags decode the registered count only.
  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (count <= CW'(AE_THRESH));
  assign almost_full  = (count >= CW'(AF_THRESH));

  // Acceptance ignores the opposite request made in the same cycle.
  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign push = write_en & ~full;
  assign pop  = read_en & ~empty;

  // Storage is never cleared. Reset only blocks a write on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout_q    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && full) overflow  <= 1'b1;
      if (read_en && empty) underflow <= 1'b1;
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (!FWFT && pop) dout_q <= mem[rd_ptr];
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // In FWFT mode the head word drives the output directly. The output shows the
  // zero in dout_q while the FIFO is empty, so data_out reads 0 after reset.
  generate
    if (FWFT) begin : g_fwft
      assign data_out = empty ? dout_q : mem[rd_ptr];
    end else begin : g_std
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed bench for param_fifo.
// It uses two instances with DEPTH=4, WIDTH=8, AF=3 and AE=1: one in standard mode
// and one in FWFT mode. A queue holds the accepted words in write order. Each pop
// takes the front word as the expected data_out value.
module tb_param_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // standard-mode instance
  logic             w = 1'b0, r = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic [WIDTH-1:0] dout;
  logic             emp, ful, aemp, aful, ovf, unf;
  logic [CW-1:0]    cnt;

  // FWFT instance
  logic             fw = 1'b0, fr = 1'b0;
  logic [WIDTH-1:0] fd = '0;
  logic [WIDTH-1:0] f_dout;
  logic             f_emp, f_ful, f_aemp, f_aful, f_ovf, f_unf;
  logic [CW-1:0]    f_cnt;

  param_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .write_en(w), .data_in(d), .read_en(r), .data_out(dout),
    .empty(emp), .full(ful), .almost_empty(aemp), .almost_full(aful), .count(cnt),
    .overflow(ovf), .underflow(unf));

  param_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .write_en(fw), .data_in(fd), .read_en(fr), .data_out(f_dout),
    .empty(f_emp), .full(f_ful), .almost_empty(f_aemp), .almost_full(f_aful), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_unf));

  int passed = 0;
  int total  = 0;

  // reference model of the standard instance
  logic [WIDTH-1:0] sb[$];
  int               mcnt  = 0;
  logic [WIDTH-1:0] mdout = '0;
  logic             movf  = 1'b0, munf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full check of the standard instance against the model.
  task automatic chk_std(input string tag);
    chk({tag, ".count"}, 32'(cnt), 32'(mcnt));
    chk({tag, ".dout"},  32'(dout), 32'(mdout));
    chk({tag, ".empty"}, 32'(emp), 32'(mcnt == 0));
    chk({tag, ".full"},  32'(ful), 32'(mcnt == DEPTH));
    chk({tag, ".aempty"}, 32'(aemp), 32'(mcnt <= 1));
    chk({tag, ".afull"}, 32'(aful), 32'(mcnt >= 3));
    chk({tag, ".ovf"},   32'(ovf), 32'(movf));
    chk({tag, ".unf"},   32'(unf), 32'(munf));
  endtask

  // One clock of standard-instance traffic. The model decides acceptance from its
  // own count before the edge.
  task automatic cyc(input string tag, input logic wi, input logic [WIDTH-1:0] di, input logic ri);
    logic acc_w, acc_r;
    acc_w = wi && (mcnt != DEPTH);
    acc_r = ri && (mcnt != 0);
    if (wi && mcnt == DEPTH) movf = 1'b1;
    if (ri && mcnt == 0)     munf = 1'b1;
    if (acc_r) mdout = sb.pop_front();
    if (acc_w) sb.push_back(di);
    mcnt = mcnt + int'(acc_w) - int'(acc_r);
    w = wi; d = di; r = ri;
    tick;
    w = 1'b0; r = 1'b0;
    chk_std(tag);
  endtask

  task automatic do_reset(input string tag, input logic wi, input logic ri);
    rst = 1'b1; w = wi; r = ri; d = 8'h99; fw = wi; fr = ri; fd = 8'h99;
    tick;
    rst = 1'b0; w = 1'b0; r = 1'b0; fw = 1'b0; fr = 1'b0;
    sb.delete();
    mcnt = 0; mdout = '0; movf = 1'b0; munf = 1'b0;
    chk_std(tag);
  endtask

  initial begin
    // reset state
    do_reset("reset", 1'b0, 1'b0);
    chk("f_reset.empty", 32'(f_emp), 32'd1);
    chk("f_reset.dout", 32'(f_dout), 32'h0);

    // underflow from reset
    cyc("underflow", 1'b0, 8'h00, 1'b1);
    do_reset("reset2", 1'b0, 1'b0);

    // fill
    cyc("push_a1", 1'b1, 8'hA1, 1'b0);
    cyc("push_b2", 1'b1, 8'hB2, 1'b0);
    cyc("push_c3", 1'b1, 8'hC3, 1'b0);
    cyc("push_d4", 1'b1, 8'hD4, 1'b0);

    // overflow, then a write while full with a pop in the same cycle: the write is dropped
    cyc("ovf_ee", 1'b1, 8'hEE, 1'b0);
    cyc("full_wr_rd", 1'b1, 8'h77, 1'b1);
    cyc("pop_b2", 1'b0, 8'h00, 1'b1);
    cyc("pop_c3", 1'b0, 8'h00, 1'b1);
    cyc("pop_d4", 1'b0, 8'h00, 1'b1);

    // a read while empty with a write: the read is ignored and the write lands
    cyc("empty_wr_rd", 1'b1, 8'h10, 1'b1);
    cyc("push_11", 1'b1, 8'h11, 1'b0);
    cyc("push_12", 1'b1, 8'h12, 1'b0);
    cyc("pop_10", 1'b0, 8'h00, 1'b1);
    cyc("pop_11", 1'b0, 8'h00, 1'b1);

    // simultaneous push and pop across the pointer wrap
    for (int i = 0; i < 6; i++) cyc($sformatf("simul%0d", i), 1'b1, 8'(8'h20 + i), 1'b1);
    cyc("pop_last", 1'b0, 8'h00, 1'b1);

    // reset mid-operation with count=3 and overflow set; reset beats write and read
    cyc("mid_30", 1'b1, 8'h30, 1'b0);
    cyc("mid_31", 1'b1, 8'h31, 1'b0);
    cyc("mid_32", 1'b1, 8'h32, 1'b0);
    do_reset("mid_reset", 1'b1, 1'b1);
    tick;
    chk_std("post_reset");
    cyc("push_44", 1'b1, 8'h44, 1'b0);
    cyc("pop_44", 1'b0, 8'h00, 1'b1);

    // FWFT: the word falls through without read_en
    fw = 1'b1; fd = 8'h5A;
    tick;
    fw = 1'b0;
    chk("fwft.dout_5a", 32'(f_dout), 32'h5A);
    chk("fwft.empty0", 32'(f_emp), 32'd0);
    tick;
    chk("fwft.hold_5a", 32'(f_dout), 32'h5A);
    fw = 1'b1; fd = 8'h6B;
    tick;
    fw = 1'b0; fr = 1'b1;
    tick;
    fr = 1'b0;
    chk("fwft.dout_6b", 32'(f_dout), 32'h6B);
    chk("fwft.count1", 32'(f_cnt), 32'd1);
    fr = 1'b1;
    tick;
    fr = 1'b0;
    chk("fwft.empty1", 32'(f_emp), 32'd1);
    chk("fwft.unf0", 32'(f_unf), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
